// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: h/v counters, prefetch address, 2-clock aligned DAC outputs
// with RGB332/grey/RGB888 expansion and a frame-latched colour-bar test pattern.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   COLOR_MODE = 0,
    parameter int   IN_W       = (COLOR_MODE == 2) ? 24 : 8,
    parameter int   XW         = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int   YW         = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic            clock_25,
    input  logic            rst,
    input  logic [IN_W-1:0] color_in,
    input  logic            test_pattern,
    output logic [XW-1:0]   next_x,
    output logic [YW-1:0]   next_y,
    output logic            next_valid,
    output logic            frame_start,
    output logic            vga_hsync,
    output logic            vga_vsync,
    output logic [7:0]      vga_red,
    output logic [7:0]      vga_green,
    output logic [7:0]      vga_blue,
    output logic            vga_sync,
    output logic            vga_clk_n,
    output logic            vga_blank_n
);

    localparam logic [31:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [31:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [31:0] HA       = H_ACTIVE;
    localparam logic [31:0] VA       = V_ACTIVE;
    localparam logic [31:0] HS_START = H_ACTIVE + H_FP;
    localparam logic [31:0] HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [31:0] VS_START = V_ACTIVE + V_FP;
    localparam logic [31:0] VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam logic [31:0] BAR_W    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam int          BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [XW-1:0] h_cnt_q, h_cnt_d;
    logic [YW-1:0] v_cnt_q, v_cnt_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [3:0]    bar_idx_q, bar_idx_d;
    logic          pat_en_q;
    logic          h_wrap, v_wrap, bar_last;
    logic          vis0, hs0, vs0, fs0;
    logic          s1_vis_q, s1_hs_q, s1_vs_q, s1_fs_q;
    logic [3:0]    s1_bar_q;
    logic [23:0]   src_rgb, bar_rgb, rgb_d, rgb_q;
    logic          hs_q, vs_q, bn_q, fs_q;

    assign h_wrap   = (32'(h_cnt_q) == H_TOTAL - 1);
    assign v_wrap   = (32'(v_cnt_q) == V_TOTAL - 1);
    assign bar_last = (32'(bar_cnt_q) == BAR_W - 1);

    // Bar counter runs alongside h_cnt so the bar index needs no divider; index 8 = remainder (black).
    always_comb begin
        h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (h_wrap) begin
            v_cnt_d   = v_wrap ? '0 : v_cnt_q + 1'b1;
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (!bar_idx_q[3]) begin
            if (bar_last) begin
                bar_cnt_d = '0;
                bar_idx_d = bar_idx_q + 4'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 1'b1;
            end
        end
    end

    assign vis0 = (32'(h_cnt_q) < HA) && (32'(v_cnt_q) < VA);
    assign hs0  = (32'(h_cnt_q) >= HS_START) && (32'(h_cnt_q) < HS_END);
    assign vs0  = (32'(v_cnt_q) >= VS_START) && (32'(v_cnt_q) < VS_END);
    assign fs0  = (h_cnt_q == '0) && (v_cnt_q == '0);

    assign next_valid = vis0;
    assign next_x     = vis0 ? h_cnt_q : '0;
    assign next_y     = vis0 ? v_cnt_q : '0;

    generate
        if (COLOR_MODE == 2) begin : g_rgb888
            assign src_rgb = color_in[23:0];
        end else if (COLOR_MODE == 1) begin : g_grey
            assign src_rgb = {3{color_in[7:0]}};
        end else begin : g_rgb332
            assign src_rgb = {color_in[7:5], color_in[7:5], color_in[7:6],
                              color_in[4:2], color_in[4:2], color_in[4:3],
                              {4{color_in[1:0]}}};
        end
    endgenerate

    // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
    assign bar_rgb = s1_bar_q[3] ? 24'h0 :
                     {{8{~s1_bar_q[1]}}, {8{~s1_bar_q[2]}}, {8{~s1_bar_q[0]}}};

    always_comb begin
        rgb_d = 24'h0;
        if (s1_vis_q) rgb_d = pat_en_q ? bar_rgb : src_rgb;
    end

    always_ff @(posedge clock_25 or posedge rst) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_en_q  <= 1'b0;
            s1_vis_q  <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_fs_q   <= 1'b0;
            s1_bar_q  <= '0;
            rgb_q     <= '0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            bn_q      <= 1'b0;
            fs_q      <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            // Latching only at (0,0) means pixel (0,0) already sees the new value one clock later.
            if (fs0) pat_en_q <= test_pattern;
            s1_vis_q  <= vis0;
            s1_hs_q   <= hs0;
            s1_vs_q   <= vs0;
            s1_fs_q   <= fs0;
            s1_bar_q  <= bar_idx_q;
            rgb_q     <= rgb_d;
            hs_q      <= s1_hs_q ? HS_POL : ~HS_POL;
            vs_q      <= s1_vs_q ? VS_POL : ~VS_POL;
            bn_q      <= s1_vis_q;
            fs_q      <= s1_fs_q;
        end
    end

    assign {vga_red, vga_green, vga_blue} = rgb_q;
    assign vga_hsync   = hs_q;
    assign vga_vsync   = vs_q;
    assign vga_blank_n = bn_q;
    assign frame_start = fs_q;
    assign vga_sync    = 1'b0;
    assign vga_clk_n   = ~clock_25;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 RGB332, grey mode, a small RGB888 raster for the
// colour bars, and a tiny active-high-hsync raster for mid-line reset and full-frame timing.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // default timing, RGB332
    logic [7:0] c0 = 8'hE0;
    logic       tp0 = 1'b0;
    logic [9:0] nx0, ny0;
    logic       nv0, fs0, hs0, vs0, sy0, ck0, bn0;
    logic [7:0] r0, g0, b0;
    vga_timing_gen d0 (
        .clock_25(clk), .rst(rst), .color_in(c0), .test_pattern(tp0),
        .next_x(nx0), .next_y(ny0), .next_valid(nv0), .frame_start(fs0),
        .vga_hsync(hs0), .vga_vsync(vs0), .vga_red(r0), .vga_green(g0), .vga_blue(b0),
        .vga_sync(sy0), .vga_clk_n(ck0), .vga_blank_n(bn0));

    // default timing, grey
    logic [7:0] c1 = 8'h5A;
    logic       tp1 = 1'b0;
    logic [9:0] nx1, ny1;
    logic       nv1, fs1, hs1, vs1, sy1, ck1, bn1;
    logic [7:0] r1, g1, b1;
    vga_timing_gen #(.COLOR_MODE(1)) d1 (
        .clock_25(clk), .rst(rst), .color_in(c1), .test_pattern(tp1),
        .next_x(nx1), .next_y(ny1), .next_valid(nv1), .frame_start(fs1),
        .vga_hsync(hs1), .vga_vsync(vs1), .vga_red(r1), .vga_green(g1), .vga_blue(b1),
        .vga_sync(sy1), .vga_clk_n(ck1), .vga_blank_n(bn1));

    // 18 px wide (bars of 2 plus 2 remainder), 25x6 frame = 150 clocks, RGB888
    logic [23:0] cp = 24'h123456;
    logic        tpp = 1'b0;
    logic [4:0]  nxp;
    logic [2:0]  nyp;
    logic        nvp, fsp, hsp, vsp, syp, ckp, bnp;
    logic [7:0]  rp, gp, bp;
    vga_timing_gen #(.H_ACTIVE(18), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .COLOR_MODE(2)) dp (
        .clock_25(clk), .rst(rst), .color_in(cp), .test_pattern(tpp),
        .next_x(nxp), .next_y(nyp), .next_valid(nvp), .frame_start(fsp),
        .vga_hsync(hsp), .vga_vsync(vsp), .vga_red(rp), .vga_green(gp), .vga_blue(bp),
        .vga_sync(syp), .vga_clk_n(ckp), .vga_blank_n(bnp));

    // 12x7 frame, active-high hsync
    logic [7:0] cs = 8'hFF;
    logic       tps = 1'b0;
    logic [3:0] nxs;
    logic [2:0] nys;
    logic       nvs, fss, hss, vss, sys, cks, bns;
    logic [7:0] rs, gs, bs;
    vga_timing_gen #(.H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)) ds (
        .clock_25(clk), .rst(rst_s), .color_in(cs), .test_pattern(tps),
        .next_x(nxs), .next_y(nys), .next_valid(nvs), .frame_start(fss),
        .vga_hsync(hss), .vga_vsync(vss), .vga_red(rs), .vga_green(gs), .vga_blue(bs),
        .vga_sync(sys), .vga_clk_n(cks), .vga_blank_n(bns));

    initial begin
        // small raster: reset values, run into the hsync window, then reset mid-line
        repeat (5) tick();
        chk("s_rst_hs", hss, 0);
        chk("s_rst_vs", vss, 1);
        chk("s_rst_rgb", {rs, gs, bs}, 0);
        chk("s_rst_bn", bns, 0);
        chk("s_rst_fs", fss, 0);
        rst_s = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            if (c == 2)  chk("s_fs_first", fss, 1);
            if (c == 5)  chk("s_rgb_vis", {rs, gs, bs}, 24'hFFFFFF);
            if (c == 5)  chk("s_bn_vis", bns, 1);
            if (c == 10) chk("s_hs_pre", hss, 0);
            if (c == 11) chk("s_hs_act", hss, 1);
            if (c < 11) tick();
        end
        rst_s = 1'b1;
        #1;
        chk("s_mid_hs", hss, 0);
        chk("s_mid_vs", vss, 1);
        chk("s_mid_rgb", {rs, gs, bs}, 0);
        chk("s_mid_bn", bns, 0);
        chk("s_mid_fs", fss, 0);
        chk("s_mid_nx", nxs, 0);
        chk("s_mid_nv", nvs, 1);
        @(negedge clk);
        repeat (2) tick();
        rst_s = 1'b0;
        for (int c = 0; c <= 90; c++) begin
            case (c)
                2:  chk("s_fs", fss, 1);
                7:  begin chk("s_nx7", nxs, 7); chk("s_nv7", nvs, 1); end
                8:  begin chk("s_nx8", nxs, 0); chk("s_nv8", nvs, 0); end
                10: begin chk("s_hs10", hss, 0); chk("s_bn10", bns, 0); chk("s_rgb10", {rs, gs, bs}, 0); end
                11: chk("s_hs11", hss, 1);
                12: chk("s_hs12", hss, 1);
                13: chk("s_hs13", hss, 0);
                15: begin chk("s_ny15", nys, 1); chk("s_nx15", nxs, 3); end
                23: chk("s_hs23", hss, 1);
                24: chk("s_hs24", hss, 1);
                25: chk("s_hs25", hss, 0);
                36: begin chk("s_ny36", nys, 3); chk("s_nv36", nvs, 1); end
                48: begin chk("s_ny48", nys, 0); chk("s_nv48", nvs, 0); end
                61: chk("s_vs61", vss, 1);
                62: chk("s_vs62", vss, 0);
                73: chk("s_vs73", vss, 0);
                74: chk("s_vs74", vss, 1);
                85: chk("s_fs85", fss, 0);
                86: chk("s_fs86", fss, 1);
                default: ;
            endcase
            tick();
        end

        // default-timing instances, held in reset the whole time so far
        chk("rst_hs", hs0, 1);
        chk("rst_vs", vs0, 1);
        chk("rst_rgb", {r0, g0, b0}, 0);
        chk("rst_bn", bn0, 0);
        chk("rst_fs", fs0, 0);
        rst = 1'b0;
        for (int c = 0; c <= 1460; c++) begin
            case (c)
                0: begin
                    chk("fs_c0", fs0, 0); chk("nx_c0", nx0, 0); chk("ny_c0", ny0, 0);
                    chk("nv_c0", nv0, 1); chk("sync0", sy0, 0); chk("clkn", ck0, 1);
                end
                1: begin chk("fs_c1", fs0, 0); chk("nx_c1", nx0, 1); end
                2: begin
                    chk("fs_c2", fs0, 1); chk("bn_c2", bn0, 1);
                    chk("rgb_E0", {r0, g0, b0}, 24'hFF0000);
                    chk("grey_5A", {r1, g1, b1}, 24'h5A5A5A);
                    chk("p_fs0", fsp, 1); chk("p_rgb0", {rp, gp, bp}, 24'h123456);
                end
                3: chk("fs_c3", fs0, 0);
                5: chk("rgb_03", {r0, g0, b0}, 24'h0000FF);
                40: chk("p_nochg", {rp, gp, bp}, 24'h123456);
                152: begin chk("p_fs1", fsp, 1); chk("p_bar0", {rp, gp, bp}, 24'hFFFFFF); end
                155: chk("p_bar1", {rp, gp, bp}, 24'hFFFF00);
                156: chk("p_bar2", {rp, gp, bp}, 24'h00FFFF);
                159: chk("p_bar3", {rp, gp, bp}, 24'h00FF00);
                160: chk("p_bar4", {rp, gp, bp}, 24'hFF00FF);
                163: chk("p_bar5", {rp, gp, bp}, 24'hFF0000);
                164: chk("p_bar6", {rp, gp, bp}, 24'h0000FF);
                166: chk("p_bar7", {rp, gp, bp}, 24'h000000);
                168: begin chk("p_rem", {rp, gp, bp}, 24'h000000); chk("p_rem_bn", bnp, 1); end
                178: chk("p_l1x1", {rp, gp, bp}, 24'hFFFFFF);
                202: chk("p_hold", {rp, gp, bp}, 24'hFFFFFF);
                302: begin chk("p_fs2", fsp, 1); chk("p_off", {rp, gp, bp}, 24'h123456); end
                639: begin chk("nx639", nx0, 639); chk("nv639", nv0, 1); end
                640: begin chk("nx640", nx0, 0); chk("nv640", nv0, 0); end
                641: chk("bn641", bn0, 1);
                642: begin chk("bn642", bn0, 0); chk("rgb642", {r0, g0, b0}, 0); end
                657: chk("hs657", hs0, 1);
                658: chk("hs658", hs0, 0);
                753: chk("hs753", hs0, 0);
                754: chk("hs754", hs0, 1);
                799: begin chk("nv799", nv0, 0); chk("ny799", ny0, 0); end
                800: begin chk("nx800", nx0, 0); chk("ny800", ny0, 1); chk("nv800", nv0, 1); end
                801: chk("nx801", nx0, 1);
                1000: chk("vs1000", vs0, 1);
                1457: chk("hs1457", hs0, 1);
                1458: chk("hs1458", hs0, 0);
                default: ;
            endcase
            if (c == 4)   c0 = 8'h03;
            if (c == 30)  tpp = 1'b1;
            if (c == 200) tpp = 1'b0;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
